// File: rtl/uart_rx_msg_buffer.sv
// Receive-side message buffer: frames UART RX bytes into messages by line-idle timeout
// and stores them in a ping-pong byte RAM. Optional macro: UART_RX_ERR_BYTE_DROP_EN.
module uart_rx_msg_buffer #(
  parameter int DATA_BUFFER_LENGTH_WIDTH = 8,
  parameter int MSG_COUNT_WIDTH          = 5,
  parameter int IDLE_BIT_TIMES           = 10
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                rx_en,
  input  logic [24:0]                         baud_divisor,
  input  logic [7:0]                          rx_data,
  input  logic                                rx_valid,
  input  logic                                rx_error,
  input  logic [7:0]                          irq_threshold,
  input  logic                                buffer_swap,
  input  logic                                irq_clear,
  input  logic [DATA_BUFFER_LENGTH_WIDTH-1:0] rd_addr,
  output logic [7:0]                          rd_data,
  output logic                                pingpong_pointer,
  output logic [MSG_COUNT_WIDTH-1:0]          message_received_count,
  output logic [MSG_COUNT_WIDTH-1:0]          read_msg_count,
  output logic [DATA_BUFFER_LENGTH_WIDTH:0]   read_length,
  output logic [7:0]                          rx_error_count,
  output logic                                irq_pending,
  output logic [7:0]                          status
);
  localparam int W      = DATA_BUFFER_LENGTH_WIDTH;
  localparam int IDLE_W = $clog2(IDLE_BIT_TIMES + 1);
  localparam logic [MSG_COUNT_WIDTH-1:0] MSG_MAX = '1;

  typedef enum logic {ST_IDLE, ST_IN_MSG} state_t;
  state_t state, state_next;

  logic [W:0]                 wr_ptr;
  logic [24:0]                prescale;
  logic [IDLE_W-1:0]          idle_cnt;
  logic                       overflow;
  logic                       swap_pending;
  logic                       accept, store, bit_tick, idle_done, msg_end, swap_go, irq_set;
  logic [MSG_COUNT_WIDTH-1:0] msg_cnt_inc;
  logic [W-1:0]               rd_addr_q;
  logic [7:0]                 mem [2**(W+1)];

`ifdef UART_RX_ERR_BYTE_DROP_EN
  assign accept = rx_valid && rx_en && !rx_error;
`else
  assign accept = rx_valid && rx_en;
`endif

  // Once the bank is full, bytes still frame the message but are not stored.
  assign store       = accept && !wr_ptr[W];
  assign bit_tick    = (prescale == baud_divisor);
  assign idle_done   = (idle_cnt == IDLE_W'(IDLE_BIT_TIMES));
  assign swap_go     = (swap_pending || buffer_swap) && (state == ST_IDLE) && !accept;
  assign msg_cnt_inc = message_received_count + 1'b1;
  assign irq_set     = msg_end && (message_received_count != MSG_MAX) &&
                       (irq_threshold != 8'd0) && (32'(msg_cnt_inc) == 32'(irq_threshold));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_next = state;
    msg_end    = 1'b0;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_IN_MSG;
      ST_IN_MSG: if (!accept && idle_done) begin
        state_next = ST_IDLE;
        msg_end    = 1'b1;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state    <= ST_IDLE;
      prescale <= '0;
      idle_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept || state == ST_IDLE) begin
        prescale <= '0;
        idle_cnt <= '0;
      end else if (bit_tick) begin
        prescale <= '0;
        if (!idle_done) idle_cnt <= idle_cnt + 1'b1;
      end else begin
        prescale <= prescale + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pingpong_pointer       <= 1'b0;
      wr_ptr                 <= '0;
      message_received_count <= '0;
      read_msg_count         <= '0;
      read_length            <= '0;
      overflow               <= 1'b0;
      swap_pending           <= 1'b0;
      irq_pending            <= 1'b0;
      rx_error_count         <= '0;
    end else begin
      if (swap_go) begin
        pingpong_pointer       <= ~pingpong_pointer;
        read_length            <= wr_ptr;
        read_msg_count         <= message_received_count;
        wr_ptr                 <= '0;
        message_received_count <= '0;
        overflow               <= 1'b0;
        swap_pending           <= 1'b0;
      end else begin
        if (buffer_swap) swap_pending <= 1'b1;
        if (store) wr_ptr <= wr_ptr + 1'b1;
        if (accept && wr_ptr[W]) overflow <= 1'b1;
        if (msg_end && message_received_count != MSG_MAX)
          message_received_count <= msg_cnt_inc;
      end
      // A new interrupt beats a clear arriving in the same cycle.
      if (irq_set) irq_pending <= 1'b1;
      else if (irq_clear || swap_go) irq_pending <= 1'b0;
      if (rx_error) rx_error_count <= rx_error_count + 1'b1;
    end
  end

  // NOTE: the byte RAM is not reset; stale bytes are unreachable because read_length clears.
  always_ff @(posedge clk) begin
    if (store) mem[{~pingpong_pointer, wr_ptr[W-1:0]}] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q <= '0;
      rd_data   <= '0;
    end else begin
      rd_addr_q <= rd_addr;
      rd_data   <= mem[{pingpong_pointer, rd_addr_q}];
    end
  end

  assign status = {3'b000, (read_length != '0), swap_pending, overflow, irq_pending,
                   (state == ST_IN_MSG)};

endmodule
